dsp48a1_mac_sequencer: RTL and testbench

- Controller that turns one DSP48A1 slice into a streaming signed dot-product (MAC) engine.
- A job is started with a length LEN. The block accepts LEN operand tuples (A, B, D) over a valid/ready stream and issues each tuple to the slice. It drives the slice's OPMODE so P accumulates M, compensating for the slice's pipeline.
- When the pipeline drains, the final P is returned on a valid/ready result port.
- Sits between the system bus/stream fabric and the DSP48A1 instance. Slice configuration: A0/B0 = 0; A1/B1/M/P/OPMODE registers = 1.

---
 rtl/dsp48a1_pkg.sv | 39 +++
 rtl/dsp_issue_pipe.sv | 40 ++++
 rtl/dsp48a1_mac_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dsp48a1_mac_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared OPMODE field layout, accumulate/hold opcodes and sequencer state
// encoding for the DSP48A1 MAC sequencer.
package dsp48a1_pkg;

    localparam int OPM_X_LSB      = 0;
    localparam int OPM_Z_LSB      = 2;
    localparam int OPM_PREADD_BIT = 4;
    localparam int OPM_PRESUB_BIT = 6;

    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_P    = 2'd2;

    localparam logic [7:0] OP_FIRST = (8'(X_M)    << OPM_X_LSB) | (8'(Z_ZERO) << OPM_Z_LSB);
    localparam logic [7:0] OP_ACC   = (8'(X_M)    << OPM_X_LSB) | (8'(Z_P)    << OPM_Z_LSB);
    localparam logic [7:0] OP_HOLD  = (8'(X_ZERO) << OPM_X_LSB) | (8'(Z_P)    << OPM_Z_LSB);

    localparam int P_LAT_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } mac_state_e;

    // Merge the job's pre-adder settings into an X/Z opcode.
    function automatic logic [7:0] with_preadd(input logic [7:0] op,
                                               input logic       use_pre,
                                               input logic       sub);
        logic [7:0] w_op;
        w_op                 = op;
        w_op[OPM_PREADD_BIT] = use_pre;
        w_op[OPM_PRESUB_BIT] = sub;
        return w_op;
    endfunction

endpackage

// File: rtl/dsp_issue_pipe.sv
// Tracks issued tuples through the slice pipeline: selects the OPMODE that
// must follow each tuple and reports when nothing is left in flight.
module dsp_issue_pipe
    import dsp48a1_pkg::*;
#(
    parameter int P_LAT = P_LAT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_issue,
    input  logic       i_first,
    output logic [7:0] o_opmode_xz,
    output logic       o_drained
);

    logic [P_LAT-1:0] r_valid;
    // Only stage 0 needs the first flag: OPMODE is chosen one cycle after issue.
    logic             r_first;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid <= '0;
            r_first <= 1'b0;
        end else begin
            r_valid <= {r_valid[P_LAT-2:0], i_issue};
            r_first <= i_issue & i_first;
        end
    end

    always_comb begin
        o_opmode_xz = OP_HOLD;
        if (r_valid[0]) begin
            o_opmode_xz = r_first ? OP_FIRST : OP_ACC;
        end
    end

    // Empty once the last tuple's product has been added into P.
    assign o_drained = ~|r_valid;

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Streams (A,B,D) tuples into a DSP48A1 slice configured as a signed MAC and
// returns the accumulated P once the slice pipeline has drained.
module dsp48a1_mac_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int P_LAT = P_LAT_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_use_preadd,
    input  logic             i_pre_sub,
    output logic             o_busy,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [17:0]      i_s_a,
    input  logic [17:0]      i_s_b,
    input  logic [17:0]      i_s_d,
    output logic             o_r_valid,
    input  logic             i_r_ready,
    output logic [47:0]      o_r_data,
    output logic [17:0]      o_dsp_a,
    output logic [17:0]      o_dsp_b,
    output logic [17:0]      o_dsp_d,
    output logic [7:0]       o_dsp_opmode,
    output logic             o_dsp_ce,
    output logic             o_dsp_rst,
    input  logic [47:0]      i_dsp_p,
    output mac_state_e       o_dbg_state
);

    // Stream handshake: a tuple moves on an edge where S_VALID and S_READY are
    // both high; S_READY never depends on S_VALID. Result side likewise.
    mac_state_e       r_state;
    mac_state_e       w_next_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_issued;
    logic             r_preadd;
    logic             r_presub;
    logic             r_busy;
    logic             r_r_valid;
    logic [47:0]      r_r_data;
    logic [17:0]      r_dsp_a;
    logic [17:0]      r_dsp_b;
    logic [17:0]      r_dsp_d;
    logic [7:0]       r_dsp_opmode;
    logic             r_dsp_ce;
    logic             r_dsp_rst;

    logic             w_start;
    logic             w_xfer;
    logic             w_last_xfer;
    logic             w_res_done;
    logic [7:0]       w_pipe_op;
    logic             w_drained;

    assign w_start     = i_start && (r_state == ST_IDLE);
    assign o_s_ready   = (r_state == ST_ACCUM) && (r_issued < r_len);
    assign w_xfer      = i_s_valid && o_s_ready;
    // Compare before incrementing so LEN = all-ones never needs a wrapped count.
    assign w_last_xfer = w_xfer && (r_issued == r_len - 1'b1);
    assign w_res_done  = (r_state == ST_RESULT) && i_r_ready;

    dsp_issue_pipe #(
        .P_LAT (P_LAT)
    ) u_issue_pipe (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_issue     (w_xfer),
        .i_first     (r_issued == '0),
        .o_opmode_xz (w_pipe_op),
        .o_drained   (w_drained)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = (i_len == '0) ? ST_RESULT : ST_ACCUM;
                end
            end
            ST_ACCUM:  if (w_last_xfer) w_next_state = ST_DRAIN;
            ST_DRAIN:  if (w_drained)   w_next_state = ST_RESULT;
            ST_RESULT: if (i_r_ready)   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_len        <= '0;
            r_issued     <= '0;
            r_preadd     <= 1'b0;
            r_presub     <= 1'b0;
            r_busy       <= 1'b0;
            r_r_valid    <= 1'b0;
            r_r_data     <= '0;
            r_dsp_a      <= '0;
            r_dsp_b      <= '0;
            r_dsp_d      <= '0;
            r_dsp_opmode <= OP_HOLD;
            r_dsp_ce     <= 1'b0;
            r_dsp_rst    <= 1'b1;
        end else begin
            r_dsp_rst <= 1'b0;
            r_dsp_ce  <= 1'b1;
            // Bubbles feed zeros so a stray accumulate could never add garbage.
            r_dsp_a   <= w_xfer ? i_s_a : '0;
            r_dsp_b   <= w_xfer ? i_s_b : '0;
            r_dsp_d   <= w_xfer ? i_s_d : '0;

            if (w_start) begin
                r_len    <= i_len;
                r_preadd <= i_use_preadd;
                r_presub <= i_pre_sub;
                r_issued <= '0;
                r_busy   <= 1'b1;
                if (i_len == '0) begin
                    r_r_data  <= '0;
                    r_r_valid <= 1'b1;
                end
            end else if (w_xfer) begin
                r_issued <= r_issued + 1'b1;
            end

            if ((r_state == ST_DRAIN) && w_drained) begin
                r_r_data  <= i_dsp_p;
                r_r_valid <= 1'b1;
            end

            if (w_res_done) begin
                r_r_valid <= 1'b0;
                r_busy    <= 1'b0;
            end

            // Pre-adder bits go out with START so the slice has them registered
            // before the first tuple reaches its B1 stage.
            if (w_start) begin
                r_dsp_opmode <= with_preadd(OP_HOLD, i_use_preadd, i_pre_sub);
            end else if ((r_state == ST_ACCUM) || (r_state == ST_DRAIN)) begin
                r_dsp_opmode <= with_preadd(w_pipe_op, r_preadd, r_presub);
            end else if (w_res_done) begin
                r_dsp_opmode <= OP_HOLD;
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_r_valid    = r_r_valid;
    assign o_r_data     = r_r_data;
    assign o_dsp_a      = r_dsp_a;
    assign o_dsp_b      = r_dsp_b;
    assign o_dsp_d      = r_dsp_d;
    assign o_dsp_opmode = r_dsp_opmode;
    assign o_dsp_ce     = r_dsp_ce;
    assign o_dsp_rst    = r_dsp_rst;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer with a behavioural DSP48A1 slice attached
// and a dot-product reference model for the random jobs.
module tb_dsp48a1_mac_sequencer;
    import dsp48a1_pkg::*;

    localparam int LW = 8;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [LW-1:0] len;
    logic          use_preadd;
    logic          pre_sub;
    logic          busy;
    logic          s_valid;
    logic          s_ready;
    logic [17:0]   s_a;
    logic [17:0]   s_b;
    logic [17:0]   s_d;
    logic          r_valid;
    logic          r_ready;
    logic [47:0]   r_data;
    logic [17:0]   dsp_a;
    logic [17:0]   dsp_b;
    logic [17:0]   dsp_d;
    logic [7:0]    dsp_opmode;
    logic          dsp_ce;
    logic          dsp_rst;
    logic [47:0]   dsp_p;
    mac_state_e    dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [47:0] exp_q[$];
    logic [17:0] job_a[256];
    logic [17:0] job_b[256];
    logic [17:0] job_d[256];

    dsp48a1_mac_sequencer #(
        .LEN_W (LW),
        .P_LAT (3)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_len        (len),
        .i_use_preadd (use_preadd),
        .i_pre_sub    (pre_sub),
        .o_busy       (busy),
        .i_s_valid    (s_valid),
        .o_s_ready    (s_ready),
        .i_s_a        (s_a),
        .i_s_b        (s_b),
        .i_s_d        (s_d),
        .o_r_valid    (r_valid),
        .i_r_ready    (r_ready),
        .o_r_data     (r_data),
        .o_dsp_a      (dsp_a),
        .o_dsp_b      (dsp_b),
        .o_dsp_d      (dsp_d),
        .o_dsp_opmode (dsp_opmode),
        .o_dsp_ce     (dsp_ce),
        .o_dsp_rst    (dsp_rst),
        .i_dsp_p      (dsp_p),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- DSP48A1 slice model (A1/B1, M, P, OPMODE registered) ----------------
    logic signed [17:0] sl_a1;
    logic signed [17:0] sl_b1;
    logic signed [35:0] sl_m;
    logic [47:0]        sl_p;
    logic [7:0]         sl_opm;

    always @(posedge clk) begin
        if (dsp_rst) begin
            sl_a1  <= '0;
            sl_b1  <= '0;
            sl_m   <= '0;
            sl_p   <= '0;
            sl_opm <= '0;
        end else if (dsp_ce) begin
            sl_a1 <= dsp_a;
            if (!sl_opm[4])     sl_b1 <= dsp_b;
            else if (sl_opm[6]) sl_b1 <= dsp_d - dsp_b;
            else                sl_b1 <= dsp_d + dsp_b;
            sl_m   <= sl_a1 * sl_b1;
            sl_opm <= dsp_opmode;
            sl_p   <= ((sl_opm[3:2] == 2'b10) ? sl_p : 48'd0)
                    + ((sl_opm[1:0] == 2'b01) ? {{12{sl_m[35]}}, sl_m} : 48'd0);
        end
    end
    assign dsp_p = sl_p;

    // ---------------- reference model ----------------
    function automatic logic [47:0] ref_dot(input int n, input bit pre, input bit sub);
        longint             acc;
        logic signed [17:0] bb;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            if (!pre)     bb = job_b[i];
            else if (sub) bb = job_d[i] - job_b[i];
            else          bb = job_d[i] + job_b[i];
            acc += longint'(signed'(job_a[i])) * longint'(bb);
        end
        return acc[47:0];
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_job(input int n, input bit pre, input bit sub);
        start      = 1'b1;
        len        = n[LW-1:0];
        use_preadd = pre;
        pre_sub    = sub;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic send_tuple(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d);
        int w;
        s_valid = 1'b1;
        s_a = a;
        s_b = b;
        s_d = d;
        w = 0;
        while (!s_ready && w < 60) begin
            tick();
            w++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles", w);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_result(input int xfer_cyc, input string name);
        int          w;
        int          hold;
        logic [47:0] e;
        w = 0;
        while (!r_valid && w < 60) begin
            tick();
            w++;
        end
        e = exp_q.pop_front();
        if (!r_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: r_valid never rose, expected data %0h", name, e);
        end else begin
            check({name, "_latency"}, 64'(cyc - xfer_cyc), 64'(4));
            check({name, "_data"}, r_data, e);
            hold = $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) begin
                tick();
                check({name, "_hold_data"}, r_data, e);
            end
            r_ready = 1'b1;
            tick();
            r_ready = 1'b0;
            check({name, "_valid_clear"}, r_valid, 0);
            check({name, "_busy_clear"}, busy, 0);
        end
    endtask

    task automatic run_job(input int n, input bit pre, input bit sub, input int gap,
                           input logic [47:0] exp, input string name);
        int xfer_cyc;
        int g;
        exp_q.push_back(exp);
        start_job(n, pre, sub);
        xfer_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            send_tuple(job_a[i], job_b[i], job_d[i]);
            xfer_cyc = cyc;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (i < n - 1) repeat (g) tick();
        end
        wait_result(xfer_cyc, name);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          first;
        int          n;
        bit          pre;
        bit          sub;
        int          gap;
        logic [47:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[3];
    logic [53:0] tups[8];

    initial begin
        int          xc;
        int          n;
        bit          pre;
        bit          sub;

        rstn = 1'b0; start = 1'b0; len = '0; use_preadd = 1'b0; pre_sub = 1'b0;
        s_valid = 1'b0; s_a = '0; s_b = '0; s_d = '0; r_ready = 1'b0;

        // tuples packed as {a, b, d}
        tups[0] = {18'd2, 18'd3, 18'd0};
        tups[1] = {18'd1, 18'd1, 18'd0};
        tups[2] = {18'd2, 18'd2, 18'd0};
        tups[3] = {18'd3, 18'd3, 18'd0};
        tups[4] = {18'h3FFFC, 18'd5, 18'd0};          // (-4, 5)
        tups[5] = {18'd2, 18'd3, 18'd5};
        tups[6] = {18'd2, 18'd3, 18'd5};
        tups[7] = {18'd2, 18'd3, 18'd5};
        vecs[0] = '{first: 0, n: 1, pre: 0, sub: 0, gap: 0, exp: 48'd6, name: "len1_2x3"};
        // 1+4+9-20 = -6
        vecs[1] = '{first: 1, n: 4, pre: 0, sub: 0, gap: 0, exp: 48'hFFFF_FFFF_FFFA, name: "len4_neg"};
        // (5-3)*2 three times
        vecs[2] = '{first: 5, n: 3, pre: 1, sub: 1, gap: 2, exp: 48'd12, name: "len3_presub_gap"};

        #12;
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_data", r_data, 0);
        check("rst_dsp_a", dsp_a, 0);
        check("rst_opmode", dsp_opmode, 8'h08);
        check("rst_dsp_ce", dsp_ce, 0);
        check("rst_dsp_rst", dsp_rst, 1);
        rstn = 1'b1;
        tick();
        check("post_rst_ce", dsp_ce, 1);
        check("post_rst_dsp_rst", dsp_rst, 0);

        s_valid = 1'b1;
        check("idle_no_ready", s_ready, 0);
        tick();
        check("idle_state", dbg_state, ST_IDLE);
        s_valid = 1'b0;

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                {job_a[i], job_b[i], job_d[i]} = tups[vecs[v].first + i];
            end
            run_job(vecs[v].n, vecs[v].pre, vecs[v].sub, vecs[v].gap, vecs[v].exp, vecs[v].name);
        end

        // Two jobs back to back, with a START during the first that must be ignored.
        exp_q.push_back(48'd10);
        start_job(2, 0, 0);
        send_tuple(18'd1, 18'd4, 18'd0);
        start = 1'b1;
        len   = 8'd1;
        tick();
        start = 1'b0;
        check("busy_start_ignored", busy, 1);
        check("state_still_accum", dbg_state, ST_ACCUM);
        send_tuple(18'd2, 18'd3, 18'd0);
        xc = cyc;
        wait_result(xc, "job_a");
        job_a[0] = 18'd2; job_b[0] = 18'd2; job_d[0] = 18'd0;
        run_job(1, 0, 0, 0, 48'd4, "job_b_first_clears");

        // Zero-length job with result back-pressure.
        start_job(0, 0, 0);
        check("len0_valid", r_valid, 1);
        check("len0_data", r_data, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("len0_hold_data", r_data, 0);
            check("len0_hold_valid", r_valid, 1);
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("len0_valid_clear", r_valid, 0);
        check("len0_idle", dbg_state, ST_IDLE);

        // Random jobs against the reference model.
        for (int j = 0; j < 10; j++) begin
            n   = $urandom_range(1, 6);
            pre = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                job_a[i] = 18'($urandom);
                job_b[i] = 18'($urandom);
                job_d[i] = 18'($urandom);
            end
            run_job(n, pre, sub, -1, ref_dot(n, pre, sub), "rand");
        end

        // Maximum length job: the sample counter ends at all-ones.
        for (int i = 0; i < 255; i++) begin
            job_a[i] = 18'($urandom);
            job_b[i] = 18'($urandom);
            job_d[i] = 18'($urandom);
        end
        run_job(255, 1, 0, 0, ref_dot(255, 1, 0), "len_max");

        // Asynchronous reset in the middle of a job.
        start_job(8, 1, 0);
        send_tuple(18'd3, 18'd4, 18'd5);
        send_tuple(18'd6, 18'd7, 18'd8);
        send_tuple(18'd9, 18'd1, 18'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_r_valid", r_valid, 0);
        check("midrst_r_data", r_data, 0);
        check("midrst_dsp_a", dsp_a, 0);
        check("midrst_opmode", dsp_opmode, 8'h08);
        check("midrst_dsp_ce", dsp_ce, 0);
        check("midrst_dsp_rst", dsp_rst, 1);
        check("midrst_state", dbg_state, ST_IDLE);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        job_a[0] = 18'd7; job_b[0] = 18'd7; job_d[0] = 18'd0;
        run_job(1, 0, 0, 0, 48'd49, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
